// File: rtl/ecc_pkg.sv
// Shared definitions for the elliptic-curve point-arithmetic blocks:
// sequencer states, multiply-step codes and the default field width.
package ecc_pkg;

    localparam int W_DEF = 256;

    typedef enum logic [2:0] {
        IDLE,
        INV,
        INV_W,
        MUL,
        MUL_W,
        FIN
    } state_e;

    // Multiply-step codes for the Jacobian-to-affine sequence.
    localparam logic [1:0] S_ZZ  = 2'd0;  // t = zi * zi
    localparam logic [1:0] S_X   = 2'd1;  // x = Xl * t
    localparam logic [1:0] S_ZZZ = 2'd2;  // t = t * zi
    localparam logic [1:0] S_Y   = 2'd3;  // y = Yl * t

endpackage

// File: rtl/jacob_affine_opsel.sv
// Operand selector for the shared modular multiplier: picks the A/B pair
// that belongs to the current multiply step. Purely combinational; the
// parent registers the result so the multiplier sees stable operands.
module jacob_affine_opsel
    import ecc_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [1:0]   s_i,
    input  logic [W-1:0] zi_i,
    input  logic [W-1:0] t_i,
    input  logic [W-1:0] xl_i,
    input  logic [W-1:0] yl_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    // Step-indexed operand mux.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave it unassigned and infer a latch.
        a_o = zi_i;
        b_o = zi_i;
        unique case (s_i)
            S_ZZ:  begin a_o = zi_i; b_o = zi_i; end
            S_X:   begin a_o = xl_i; b_o = t_i;  end
            S_ZZZ: begin a_o = t_i;  b_o = zi_i; end
            S_Y:   begin a_o = yl_i; b_o = t_i;  end
            default: begin a_o = zi_i; b_o = zi_i; end
        endcase
    end

endmodule

// File: rtl/jacob_affine_ctrl.sv
// Jacobian-to-affine conversion sequencer. Computes x = X/Z^2, y = Y/Z^3
// (mod p) by scheduling one shared inverter and one shared multiplier.
// A zero Z finishes immediately as the point at infinity; a silent
// inverter is cut off by a watchdog and reported through err.
module jacob_affine_ctrl
    import ecc_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int INV_TO = 4096
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         start,
    input  logic [W-1:0] x3,
    input  logic [W-1:0] y3,
    input  logic [W-1:0] z3,
    input  logic [W-1:0] p,
    output logic         busy,
    output logic         done,
    output logic         inf,
    output logic         err,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         inv_start,
    output logic [W-1:0] inv_a,
    input  logic         inv_done,
    input  logic [W-1:0] inv_r,
    output logic         mul_start,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    output logic [W-1:0] mod_p,
    input  logic         mul_done,
    input  logic [W-1:0] mul_r
);

    localparam int             WDW     = $clog2(INV_TO + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(INV_TO);

    state_e         state_q, state_d;
    logic [1:0]     s_q, s_d;
    logic [W-1:0]   xl_q, xl_d, yl_q, yl_d, zl_q, zl_d, p_q, p_d;
    logic [W-1:0]   zi_q, zi_d, t_q, t_d, x_q, x_d, y_q, y_d;
    logic           inf_q, inf_d, err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [W-1:0]   mul_a_q, mul_b_q, sel_a, sel_b;

    // Next-state, datapath updates and state-decoded strobes.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        zl_d    = zl_q;
        p_d     = p_q;
        zi_d    = zi_q;
        t_d     = t_q;
        x_d     = x_q;
        y_d     = y_q;
        inf_d   = inf_q;
        err_d   = err_q;
        wd_d    = wd_q;

        busy      = (state_q != IDLE);
        done      = (state_q == FIN);
        inv_start = (state_q == INV);
        mul_start = (state_q == MUL);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    xl_d  = x3;
                    yl_d  = y3;
                    zl_d  = z3;
                    p_d   = p;
                    s_d   = S_ZZ;
                    wd_d  = '0;
                    x_d   = '0;
                    y_d   = '0;
                    err_d = 1'b0;
                    inf_d = (z3 == '0);
                    state_d = (z3 == '0) ? FIN : INV;
                end
            end
            INV: begin
                // The inverter start cycle counts towards the watchdog.
                wd_d    = wd_q + 1'b1;
                state_d = INV_W;
            end
            INV_W: begin
                if (inv_done) begin
                    zi_d    = inv_r;
                    state_d = MUL;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == WD_LAST) begin
                        err_d   = 1'b1;
                        state_d = FIN;
                    end
                end
            end
            MUL: begin
                state_d = MUL_W;
            end
            MUL_W: begin
                if (mul_done) begin
                    unique case (s_q)
                        S_ZZ, S_ZZZ: t_d = mul_r;
                        S_X:         x_d = mul_r;
                        default:     y_d = mul_r;
                    endcase
                    if (s_q != S_Y) begin
                        s_d     = s_q + 2'd1;
                        state_d = MUL;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operands for the step about to be issued; fed from next-state values
    // so the product inputs are ready in the same cycle as mul_start.
    jacob_affine_opsel #(.W(W)) u_opsel (
        .s_i  (s_d),
        .zi_i (zi_d),
        .t_i  (t_d),
        .xl_i (xl_q),
        .yl_i (yl_q),
        .a_o  (sel_a),
        .b_o  (sel_b)
    );

    // Sequencer state and latched datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            s_q     <= S_ZZ;
            xl_q    <= '0;
            yl_q    <= '0;
            zl_q    <= '0;
            p_q     <= '0;
            zi_q    <= '0;
            t_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            inf_q   <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
            s_q     <= s_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            zl_q    <= zl_d;
            p_q     <= p_d;
            zi_q    <= zi_d;
            t_q     <= t_d;
            x_q     <= x_d;
            y_q     <= y_d;
            inf_q   <= inf_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    // Multiplier operands load only when a multiply is issued, so they stay
    // put until the matching mul_done.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else if (state_d == MUL) begin
            mul_a_q <= sel_a;
            mul_b_q <= sel_b;
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign inf   = inf_q;
    assign err   = err_q;
    assign inv_a = zl_q;
    assign mod_p = p_q;
    assign mul_a = mul_a_q;
    assign mul_b = mul_b_q;

endmodule

// File: tb/tb_jacob_affine_ctrl.sv
// Directed bench for jacob_affine_ctrl with behavioural inverter and
// multiplier of programmable latency.
module tb_jacob_affine_ctrl;

    localparam int W      = 8;
    localparam int INV_TO = 16;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] x3 = '0, y3 = '0, z3 = '0, p = '0;
    logic         busy, done, inf, err, inv_start, mul_start;
    logic [W-1:0] x, y, inv_a, mul_a, mul_b, mod_p;
    logic         inv_done, mul_done;
    logic [W-1:0] inv_r, mul_r;

    logic         inv_done_m = 1'b0, mul_done_m = 1'b0, mul_stray = 1'b0;
    logic [W-1:0] inv_r_m = '0, mul_r_m = '0;

    assign inv_done = inv_done_m;
    assign inv_r    = inv_r_m;
    assign mul_done = mul_done_m | mul_stray;
    assign mul_r    = mul_stray ? 8'h55 : mul_r_m;

    int  inv_lat = 3, mul_lat = 3;
    bit  inv_en = 1'b1;
    int  inv_cnt = 0, mul_pend = 0, cyc = 0;
    int  n_inv = 0, n_mul = 0, inv_cyc = 0, mul_done_cyc = 0, stab_bad = 0;
    logic [15:0]  mlog[$];
    logic [W-1:0] cap_a = '0, cap_b = '0;
    int  n_assert = 0, n_fail = 0;

    jacob_affine_ctrl #(.W(W), .INV_TO(INV_TO)) dut (
        .clk(clk), .nrst(nrst), .start(start),
        .x3(x3), .y3(y3), .z3(z3), .p(p),
        .busy(busy), .done(done), .inf(inf), .err(err), .x(x), .y(y),
        .inv_start(inv_start), .inv_a(inv_a), .inv_done(inv_done), .inv_r(inv_r),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mod_p(mod_p),
        .mul_done(mul_done), .mul_r(mul_r)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter.
    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] inv_mod(input logic [W-1:0] a, input logic [W-1:0] m);
        int r = 0;
        for (int k = 1; k < int'(m); k++)
            if ((int'(a) * k) % int'(m) == 1) r = k;
        return W'(r);
    endfunction

    // Behavioural units and start/done monitor, updated mid-cycle.
    always @(negedge clk) begin
        inv_done_m = 1'b0;
        mul_done_m = 1'b0;
        if (!nrst) begin
            inv_cnt  = 0;
            mul_pend = 0;
        end else begin
            if (inv_cnt > 0) begin
                inv_cnt--;
                if (inv_cnt == 0) begin
                    inv_done_m = 1'b1;
                    inv_r_m    = inv_mod(inv_a, mod_p);
                end
            end
            if (mul_pend > 0) begin
                if (mul_a !== cap_a || mul_b !== cap_b) stab_bad++;
                mul_pend--;
                if (mul_pend == 0) begin
                    mul_done_m   = 1'b1;
                    mul_r_m      = W'((int'(mul_a) * int'(mul_b)) % int'(mod_p));
                    mul_done_cyc = cyc;
                end
            end
            if (inv_start) begin
                n_inv++;
                inv_cyc = cyc;
                if (inv_en) inv_cnt = inv_lat;
            end
            if (mul_start) begin
                n_mul++;
                mlog.push_back({mul_a, mul_b});
                cap_a    = mul_a;
                cap_b    = mul_b;
                mul_pend = mul_lat;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; t is the accept cycle. Inputs are scrambled
    // afterwards since they only need to hold in the accept cycle.
    task automatic do_start(input logic [W-1:0] xx, input logic [W-1:0] yy,
                            input logic [W-1:0] zz, input logic [W-1:0] pp, output int t);
        x3 = xx; y3 = yy; z3 = zz; p = pp;
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
        x3 = 8'hAA; y3 = 8'hBB; z3 = 8'h00; p = 8'hCC;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_muls(input string tag, input int target);
        int k = 0;
        while (mlog.size() < target && k < 300) begin
            tick();
            k++;
        end
        chk(tag, mlog.size(), target);
    endtask

    // Hard stop in case the sequence itself stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Directed sequence.
    initial begin
        int t0, b, ni, nm;

        // Reset state
        repeat (3) tick();
        chk("rst_strobes", {26'd0, busy, done, inf, err, inv_start, mul_start}, 32'd0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_ops", {inv_a, mul_a, mul_b, mod_p}, 32'd0);
        nrst = 1'b1;
        tick();

        // Basic conversion: p=23, (5,4,2) -> (7,12)
        b = mlog.size();
        do_start(8'd5, 8'd4, 8'd2, 8'd23, t0);
        chk("acc_busy", busy, 1);
        chk("acc_inv_start", inv_start, 1);
        chk("acc_inv_a", inv_a, 2);
        chk("acc_mod_p", mod_p, 23);
        wait_done("basic_done");
        chk("basic_x", x, 7);
        chk("basic_y", y, 12);
        chk("basic_inf_err", {inf, err}, 0);
        chk("basic_busy_at_done", busy, 1);
        chk("basic_inv_cyc", inv_cyc, t0 + 1);
        chk("basic_done_cyc", cyc, t0 + 21);
        chk("basic_done_after_mul", cyc, mul_done_cyc + 1);
        chk("basic_nmul", mlog.size() - b, 4);
        chk("basic_op0", mlog[b],   16'h0C0C);
        chk("basic_op1", mlog[b+1], 16'h0506);
        chk("basic_op2", mlog[b+2], 16'h060C);
        chk("basic_op3", mlog[b+3], 16'h0403);
        tick();
        chk("basic_idle", {busy, done}, 0);
        chk("basic_x_held", x, 7);

        // Start while busy, start in done cycle, back-to-back start
        b = mlog.size();
        do_start(8'd5, 8'd4, 8'd2, 8'd23, t0);
        wait_muls("busy_reach_s1", b + 2);
        tick();
        x3 = 8'd9; y3 = 8'd9; z3 = 8'd0; p = 8'd23;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start_inf", inf, 0);
        wait_done("busy_done");
        chk("busy_x", x, 7);
        chk("busy_y", y, 12);
        chk("busy_nmul", mlog.size() - b, 4);
        x3 = 8'd1; y3 = 8'd1; z3 = 8'd1; p = 8'd23;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("fin_start_ignored", busy, 0);
        b = mlog.size();
        do_start(8'd1, 8'd1, 8'd1, 8'd23, t0);
        chk("b2b_busy", busy, 1);
        wait_done("b2b_done");
        chk("b2b_x", x, 1);
        chk("b2b_y", y, 1);
        chk("b2b_done_cyc", cyc, t0 + 21);
        chk("b2b_op0", mlog[b], 16'h0101);
        tick();

        // Point at infinity
        ni = n_inv; nm = n_mul;
        do_start(8'd9, 8'd9, 8'd0, 8'd23, t0);
        chk("inf_done", done, 1);
        chk("inf_flag", {inf, err}, 2'b10);
        chk("inf_xy", {x, y}, 0);
        chk("inf_done_cyc", cyc, t0 + 1);
        tick();
        chk("inf_idle", busy, 0);
        chk("inf_held", inf, 1);
        chk("inf_no_units", {n_inv - ni, n_mul - nm}, 0);

        // Inverter watchdog
        inv_en = 1'b0;
        nm = n_mul;
        do_start(8'd5, 8'd4, 8'd2, 8'd23, t0);
        chk("wd_inf_cleared", inf, 0);
        wait_done("wd_done");
        chk("wd_done_cyc", cyc, t0 + 1 + INV_TO);
        chk("wd_flags", {inf, err}, 2'b01);
        chk("wd_xy", {x, y}, 0);
        chk("wd_no_mul", n_mul - nm, 0);
        tick();
        chk("wd_err_held", {busy, err}, 2'b01);
        inv_en = 1'b1;

        // Reset during step s2
        b = mlog.size();
        do_start(8'd5, 8'd4, 8'd2, 8'd23, t0);
        chk("rmo_err_cleared", err, 0);
        wait_muls("rmo_reach_s2", b + 3);
        tick();
        chk("rmo_pre_x", x, 7);
        #1 nrst = 1'b0;
        #1;
        chk("rmo_strobes", {28'd0, busy, done, inv_start, mul_start}, 0);
        chk("rmo_xy", {x, y}, 0);
        tick();
        nrst = 1'b1;
        tick();
        mul_stray = 1'b1;
        tick();
        mul_stray = 1'b0;
        tick();
        chk("rmo_stray_ignored", {busy, done}, 0);
        chk("rmo_stray_xy", {x, y}, 0);
        do_start(8'd5, 8'd4, 8'd2, 8'd23, t0);
        wait_done("rmo_fresh_done");
        chk("rmo_fresh_xy", {x, y}, {8'd7, 8'd12});
        chk("rmo_fresh_cyc", cyc, t0 + 21);
        tick();

        // Latency sweep with a stray mul_done in IDLE
        inv_lat = 1; mul_lat = 7;
        mul_stray = 1'b1;
        tick();
        mul_stray = 1'b0;
        chk("sweep_stray_idle", busy, 0);
        b = mlog.size();
        do_start(8'd5, 8'd4, 8'd2, 8'd23, t0);
        wait_done("sweep17_done");
        chk("sweep17_xy", {x, y}, {8'd7, 8'd12});
        chk("sweep17_cyc", cyc, t0 + 35);
        chk("sweep17_op3", mlog[b+3], 16'h0403);
        tick();
        inv_lat = 7; mul_lat = 1;
        do_start(8'd5, 8'd4, 8'd2, 8'd23, t0);
        wait_done("sweep71_done");
        chk("sweep71_xy", {x, y}, {8'd7, 8'd12});
        chk("sweep71_cyc", cyc, t0 + 17);
        tick();

        chk("operand_stability", stab_bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
